lenet_digit_filter: RTL and testbench

Temporal vote filter between `lenet` and the VGA overlay, on the `clk100` domain. It captures each LeNet classification on the rising edge of `lenet_ready` and keeps a ring of the last `HISTORY` results with one vote counter per class. It then publishes a debounced digit with a validity flag, so the on-screen digit does not flicker from frame to frame.

---
 rtl/lenet_digit_filter_pkg.sv | 14 +
 rtl/lenet_digit_filter_history_ring.sv | 44 ++++
 rtl/lenet_digit_filter.sv | 179 +++++++++++++++++
 tb/tb_lenet_digit_filter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_digit_filter_pkg.sv
// Shared types and constants for the LeNet digit vote filter.
package lenet_filter_pkg;

   localparam int DIGIT_W             = 4;
   localparam int NUM_CLASSES_DEFAULT = 10;

   typedef enum logic [1:0] {
      IDLE,
      UPDATE,
      SCAN,
      COMMIT
   } filt_state_t;

endpackage

// File: rtl/lenet_digit_filter_history_ring.sv
// Ring of the last HISTORY accepted digits; exposes the entry about to be
// overwritten so the vote counters can retire it in the same cycle.
module digit_history_ring
   import lenet_filter_pkg::*;
#(
   parameter int HISTORY = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               i_clear,
   input  logic               i_wr_en,
   input  logic [DIGIT_W-1:0] i_wr_digit,
   output logic [DIGIT_W-1:0] o_evict_digit,
   output logic               o_evict_valid
);

   localparam int PTR_W  = (HISTORY > 1) ? $clog2(HISTORY) : 1;
   localparam int FILL_W = $clog2(HISTORY + 1);

   logic [DIGIT_W-1:0] r_mem [HISTORY];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [FILL_W-1:0]  r_fill;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < HISTORY; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_fill   <= '0;
      end else if (i_clear) begin
         for (int unsigned i = 0; i < HISTORY; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_fill   <= '0;
      end else if (i_wr_en) begin
         r_mem[r_wr_ptr] <= i_wr_digit;
         r_wr_ptr <= (r_wr_ptr == PTR_W'(HISTORY - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
         if (r_fill != FILL_W'(HISTORY)) r_fill <= r_fill + FILL_W'(1);
      end
   end

   // Once the ring is full the write slot holds the oldest entry.
   assign o_evict_digit = r_mem[r_wr_ptr];
   assign o_evict_valid = (r_fill == FILL_W'(HISTORY));

endmodule

// File: rtl/lenet_digit_filter.sv
// Temporal vote filter for LeNet classifications: per-class vote counters
// over a history ring, sequential argmax scan, registered commit.
// Optional macro LENET_FILTER_HYST_EN: a new winner must strictly out-vote
// the currently displayed digit before it replaces it.
module lenet_digit_filter
   import lenet_filter_pkg::*;
#(
   parameter int HISTORY     = 8,
   parameter int MIN_VOTES   = 5,
   parameter int NUM_CLASSES = NUM_CLASSES_DEFAULT
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         lenet_ready,
   input  logic [DIGIT_W-1:0]           lenet_digit,
   input  logic                         clear,
   output logic [DIGIT_W-1:0]           stable_digit,
   output logic                         stable_valid,
   output logic [$clog2(HISTORY+1)-1:0] vote_count,
   output logic                         result_valid,
   output logic                         overrun
);

   localparam int CNT_W = $clog2(HISTORY + 1);

   filt_state_t        r_state;
   logic               r_ready_q;
   logic [DIGIT_W-1:0] r_cur_digit;
   logic               r_pend_v;
   logic [DIGIT_W-1:0] r_pend_d;
   logic [CNT_W-1:0]   r_cnt [NUM_CLASSES];
   logic [DIGIT_W-1:0] r_scan_idx;
   logic [DIGIT_W-1:0] r_best_idx;
   logic [CNT_W-1:0]   r_best_cnt;
   logic [DIGIT_W-1:0] r_stable_digit;
   logic               r_stable_valid;
   logic [CNT_W-1:0]   r_vote_count;
   logic               r_result_valid;
   logic               r_overrun;

   logic               w_edge;
   logic               w_new_valid;
   logic               w_wr_en;
   logic [DIGIT_W-1:0] w_evict_digit;
   logic               w_evict_valid;
   logic               w_inc [NUM_CLASSES];
   logic               w_dec [NUM_CLASSES];
   logic [CNT_W-1:0]   w_cur_cnt;
   logic               w_take;
   logic [DIGIT_W-1:0] w_commit_digit;
   logic [CNT_W-1:0]   w_commit_cnt;

   assign w_edge      = lenet_ready & ~r_ready_q;
   assign w_new_valid = w_edge & ({1'b0, lenet_digit} < (DIGIT_W + 1)'(NUM_CLASSES));
   assign w_wr_en     = (r_state == UPDATE) & ~clear;

   digit_history_ring #(
      .HISTORY (HISTORY)
   ) u_ring (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_clear       (clear),
      .i_wr_en       (w_wr_en),
      .i_wr_digit    (r_cur_digit),
      .o_evict_digit (w_evict_digit),
      .o_evict_valid (w_evict_valid)
   );

   // A matching new/evicted pair raises both flags, leaving the counter as is.
   always_comb begin
      for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
         w_inc[c] = (DIGIT_W'(c) == r_cur_digit);
         w_dec[c] = w_evict_valid && (DIGIT_W'(c) == w_evict_digit);
      end
   end

   assign w_cur_cnt = r_cnt[r_stable_digit];

`ifdef LENET_FILTER_HYST_EN
   assign w_take = (r_best_cnt > w_cur_cnt);
`else
   assign w_take = 1'b1;
`endif

   assign w_commit_digit = w_take ? r_best_idx : r_stable_digit;
   assign w_commit_cnt   = w_take ? r_best_cnt : w_cur_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state        <= IDLE;
         r_ready_q      <= 1'b0;
         r_cur_digit    <= '0;
         r_pend_v       <= 1'b0;
         r_pend_d       <= '0;
         for (int unsigned c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
         r_scan_idx     <= '0;
         r_best_idx     <= '0;
         r_best_cnt     <= '0;
         r_stable_digit <= '0;
         r_stable_valid <= 1'b0;
         r_vote_count   <= '0;
         r_result_valid <= 1'b0;
         r_overrun      <= 1'b0;
      end else begin
         r_ready_q      <= lenet_ready;
         r_result_valid <= 1'b0;
         if (clear) begin
            r_state        <= IDLE;
            r_cur_digit    <= '0;
            r_pend_v       <= 1'b0;
            r_pend_d       <= '0;
            for (int unsigned c = 0; c < NUM_CLASSES; c++) r_cnt[c] <= '0;
            r_scan_idx     <= '0;
            r_best_idx     <= '0;
            r_best_cnt     <= '0;
            r_stable_digit <= '0;
            r_stable_valid <= 1'b0;
            r_vote_count   <= '0;
            r_overrun      <= 1'b0;
         end else begin
            // Edges arriving while busy go to the one-deep slot.
            if (r_state != IDLE && w_new_valid) begin
               if (r_pend_v) begin
                  r_overrun <= 1'b1;
               end else begin
                  r_pend_v <= 1'b1;
                  r_pend_d <= lenet_digit;
               end
            end
            case (r_state)
               IDLE: begin
                  if (r_pend_v) begin
                     r_cur_digit <= r_pend_d;
                     r_pend_v    <= w_new_valid;
                     r_pend_d    <= lenet_digit;
                     r_state     <= UPDATE;
                  end else if (w_new_valid) begin
                     r_cur_digit <= lenet_digit;
                     r_state     <= UPDATE;
                  end
               end
               UPDATE: begin
                  for (int unsigned c = 0; c < NUM_CLASSES; c++) begin
                     if (w_inc[c] && !w_dec[c]) r_cnt[c] <= r_cnt[c] + CNT_W'(1);
                     else if (!w_inc[c] && w_dec[c]) r_cnt[c] <= r_cnt[c] - CNT_W'(1);
                  end
                  r_scan_idx <= '0;
                  r_best_idx <= '0;
                  r_best_cnt <= '0;
                  r_state    <= SCAN;
               end
               SCAN: begin
                  if (r_cnt[r_scan_idx] > r_best_cnt) begin
                     r_best_cnt <= r_cnt[r_scan_idx];
                     r_best_idx <= r_scan_idx;
                  end
                  if (r_scan_idx == DIGIT_W'(NUM_CLASSES - 1)) r_state <= COMMIT;
                  else r_scan_idx <= r_scan_idx + DIGIT_W'(1);
               end
               COMMIT: begin
                  r_stable_digit <= w_commit_digit;
                  r_vote_count   <= w_commit_cnt;
                  r_stable_valid <= (w_commit_cnt >= CNT_W'(MIN_VOTES));
                  r_result_valid <= 1'b1;
                  r_state        <= IDLE;
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign stable_digit = r_stable_digit;
   assign stable_valid = r_stable_valid;
   assign vote_count   = r_vote_count;
   assign result_valid = r_result_valid;
   assign overrun      = r_overrun;

endmodule

// File: tb/tb_lenet_digit_filter.sv
// Self-checking bench for lenet_digit_filter: directed scenarios plus random
// traffic, all checked against a transaction-level vote model.
module tb_lenet_digit_filter;

   localparam int HISTORY   = 8;
   localparam int MIN_VOTES = 5;
   localparam int NC        = 10;
   localparam int LAT       = NC + 3;
   localparam int CW        = $clog2(HISTORY + 1);

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          lenet_ready = 1'b0;
   logic [3:0]    lenet_digit = '0;
   logic          clear = 1'b0;
   logic [3:0]    stable_digit;
   logic          stable_valid;
   logic [CW-1:0] vote_count;
   logic          result_valid;
   logic          overrun;

   always #5 clk = ~clk;

   lenet_digit_filter #(
      .HISTORY     (HISTORY),
      .MIN_VOTES   (MIN_VOTES),
      .NUM_CLASSES (NC)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .lenet_ready  (lenet_ready),
      .lenet_digit  (lenet_digit),
      .clear        (clear),
      .stable_digit (stable_digit),
      .stable_valid (stable_valid),
      .vote_count   (vote_count),
      .result_valid (result_valid),
      .overrun      (overrun)
   );

   int n_chk = 0;
   int n_pass = 0;
   int n_pulse = 0;

   typedef struct {int cyc; int d; int v;} pulse_t;
   pulse_t pq[$];
   int     hist[$];
   int     cyc = 0;
   int     free_at = 0;
   int     pend_d = 0;
   int     sched_d = 0;
   bit     pend_v = 0;
   bit     prev_rdy = 0;
   int     e_d = 0;
   int     e_v = 0;
   bit     e_ok = 0;
   bit     e_ovr = 0;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
   endtask

   task automatic model_clear();
      hist.delete();
      pq.delete();
      e_d = 0; e_v = 0; e_ok = 0; e_ovr = 0;
      sched_d = 0;
      pend_v = 0;
   endtask

   // Majority over the last HISTORY accepted digits, lowest index on ties.
   task automatic start(input int d);
      int cnt [NC];
      int best;
      hist.push_back(d);
      if (hist.size() > HISTORY) void'(hist.pop_front());
      for (int k = 0; k < NC; k++) cnt[k] = 0;
      foreach (hist[i]) cnt[hist[i]]++;
      best = 0;
      for (int k = 1; k < NC; k++) if (cnt[k] > cnt[best]) best = k;
`ifdef LENET_FILTER_HYST_EN
      if (!(cnt[best] > cnt[sched_d])) best = sched_d;
`endif
      pq.push_back('{cyc + LAT, best, cnt[best]});
      sched_d = best;
      free_at = cyc + LAT;
   endtask

   task automatic tick(input bit rdy, input int dig, input bit clr);
      bit rv, edge_s, ok;
      @(negedge clk);
      rv = 0;
      if (pq.size() > 0 && pq[0].cyc == cyc) begin
         e_d = pq[0].d; e_v = pq[0].v; e_ok = (pq[0].v >= MIN_VOTES);
         void'(pq.pop_front());
         rv = 1;
      end
      chk("result_valid", int'(result_valid), int'(rv));
      chk("stable_digit", int'(stable_digit), e_d);
      chk("stable_valid", int'(stable_valid), int'(e_ok));
      chk("vote_count", int'(vote_count), e_v);
      chk("overrun", int'(overrun), int'(e_ovr));
      if (result_valid) n_pulse++;
      lenet_ready = rdy;
      lenet_digit = dig[3:0];
      clear = clr;
      edge_s = rdy && !prev_rdy;
      ok = edge_s && (dig < NC);
      prev_rdy = rdy;
      if (clr) begin
         model_clear();
         free_at = cyc + 1;
      end else if (cyc >= free_at) begin
         if (pend_v) begin
            start(pend_d);
            pend_v = ok;
            pend_d = dig;
         end else if (ok) begin
            start(dig);
         end
      end else if (ok) begin
         if (pend_v) e_ovr = 1;
         else begin pend_v = 1; pend_d = dig; end
      end
      cyc++;
   endtask

   task automatic send(input int d, input int gap);
      tick(1, d, 0);
      repeat (gap - 1) tick(0, d, 0);
   endtask

   task automatic do_reset(input bit rdy_at_release);
      #2 rst_n = 1'b0;
      lenet_ready = rdy_at_release;
      clear = 1'b0;
      #1;
      chk("rst_result_valid", int'(result_valid), 0);
      chk("rst_stable_digit", int'(stable_digit), 0);
      chk("rst_stable_valid", int'(stable_valid), 0);
      chk("rst_vote_count", int'(vote_count), 0);
      chk("rst_overrun", int'(overrun), 0);
      model_clear();
      prev_rdy = 0;
      free_at = cyc;
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      #1;
      do_reset(0);

      repeat (5) send(3, 20);
      chk("plan1_digit", int'(stable_digit), 3);
      chk("plan1_votes", int'(vote_count), 5);
      chk("plan1_valid", int'(stable_valid), 1);

      repeat (8) send(3, 20);
      repeat (4) send(7, 20);
      chk("plan2_tie_digit", int'(stable_digit), 3);
      chk("plan2_tie_votes", int'(vote_count), 4);
      chk("plan2_tie_valid", int'(stable_valid), 0);
      send(7, 20);
      chk("plan2_digit", int'(stable_digit), 7);
      chk("plan2_votes", int'(vote_count), 5);

      p0 = n_pulse;
      send(12, 20);
      chk("invalid_no_pulse", n_pulse - p0, 0);
      chk("invalid_votes", int'(vote_count), 5);

      p0 = n_pulse;
      tick(1, 2, 0); tick(0, 0, 0);
      tick(1, 5, 0); tick(0, 0, 0);
      tick(1, 6, 0);
      repeat (35) tick(0, 0, 0);
      chk("busy_two_pulses", n_pulse - p0, 2);
      chk("busy_overrun", int'(overrun), 1);

      p0 = n_pulse;
      tick(1, 5, 1);
      repeat (20) tick(0, 0, 0);
      chk("clear_no_pulse", n_pulse - p0, 0);
      chk("clear_digit", int'(stable_digit), 0);
      chk("clear_overrun", int'(overrun), 0);
      send(4, 20);
      chk("clear_next_votes", int'(vote_count), 1);
      chk("clear_next_valid", int'(stable_valid), 0);

      tick(1, 4, 0);
      repeat (5) tick(0, 0, 0);
      do_reset(0);
      p0 = n_pulse;
      repeat (25) tick(0, 0, 0);
      chk("rst_scan_no_pulse", n_pulse - p0, 0);

      do_reset(1);
      tick(1, 9, 0);
      repeat (20) tick(0, 0, 0);
      chk("rst_high_edge_digit", int'(stable_digit), 9);
      chk("rst_high_edge_votes", int'(vote_count), 1);

      for (int phase = 0; phase < 2; phase++) begin
         for (int i = 0; i < 1500; i++) begin
            bit rdy, clr;
            int dig, r;
            rdy = (phase == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) == 0);
            r = $urandom_range(0, 19);
            if (r < 2) dig = $urandom_range(10, 15);
            else if (r < 12) dig = (r < 7) ? 1 : 8;
            else dig = $urandom_range(0, 9);
            clr = ($urandom_range(0, 299) == 0);
            tick(rdy, dig, clr);
         end
      end
      repeat (30) tick(0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
